// File: rtl/an_code_pkg.sv
// Shared AN-code constants and types, common to the encoder and the downstream decoder
// so the modulus and widths cannot drift apart.
package an_code_pkg;

  localparam int unsigned A     = 19;
  localparam int unsigned N_W   = 4;
  localparam int unsigned A_W   = 5;
  localparam int unsigned AN_W  = 9;
  localparam int unsigned CNT_W = $clog2(N_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest code width that holds the largest product (2^n_w-1)*a without overflow.
  function automatic int unsigned an_w_required(input int unsigned a, input int unsigned n_w);
    return $clog2(((2 ** n_w) - 1) * a + 1);
  endfunction

endpackage

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: code = A*N built by shift-and-add, one data bit per cycle,
// with an optional error mask XORed onto the presented word for in-system decoder testing.
module an_encoder_seq
  import an_code_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_W-1:0]  in_data,
  input  logic [AN_W-1:0] in_err_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AN_W-1:0] out_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);

  if ((AN_W < an_w_required(A, N_W)) || (A >= (2 ** A_W))) begin : g_width_check
    $error("an_encoder_seq: AN_W or A_W too small for A and N_W");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AN_W-1:0]   r_acc;
  logic [AN_W-1:0]   w_acc_nxt;
  logic [N_W-1:0]    r_n;
  logic [N_W-1:0]    w_n_nxt;
  logic [AN_W-1:0]   r_mask;
  logic [AN_W-1:0]   w_mask_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [AN_W-1:0]   w_addend;

  // Next-state and datapath update; acc always carries the clean product, mask stays separate.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_n_nxt     = r_n;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    if (r_n[r_cnt]) begin
      w_addend = AN_W'(A) << r_cnt;
    end else begin
      w_addend = {AN_W{1'b0}};
    end
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_n_nxt     = in_data;
          w_mask_nxt  = in_err_mask;
          w_acc_nxt   = {AN_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = MUL;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL: begin
        w_acc_nxt = r_acc + w_addend;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = MUL;
        end
      end
      DONE: begin
        // A new word may be taken in the same cycle the current one is consumed.
        if (out_ready && in_valid) begin
          w_n_nxt     = in_data;
          w_mask_nxt  = in_err_mask;
          w_acc_nxt   = {AN_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = MUL;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= {AN_W{1'b0}};
      r_n     <= {N_W{1'b0}};
      r_mask  <= {AN_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_n     <= w_n_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out_valid = (r_state == DONE);
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_code  = out_valid ? (r_acc ^ r_mask) : {AN_W{1'b0}};

endmodule

// File: tb/tb_an_encoder_seq.sv
// Self-checking bench for an_encoder_seq: directed scenarios plus randomized traffic
// compared against an arithmetic reference (19*N) ^ mask.
module tb_an_encoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [8:0] in_err_mask;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_code;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  an_encoder_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_err_mask (in_err_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_code(input int n, input logic [8:0] mask);
    int prod;
    prod = 19 * n;
    return 32'(prod[8:0] ^ mask);
  endfunction

  // One full transaction from IDLE: accept, check latency, hold for `hold` cycles, consume.
  task automatic run_txn(input int n, input logic [8:0] mask, input int hold, input string tag);
    int          lat;
    logic [31:0] exp;
    exp         = ref_code(n, mask);
    in_valid    = 1'b1;
    in_data     = 4'(n);
    in_err_mask = mask;
    lat = 0;
    while (!in_ready && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    in_valid    = 1'b0;
    in_data     = 4'(n + 5);
    in_err_mask = 9'h1ff;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    for (int d = 0; d < hold; d++) begin
      check({tag, "_hold_code"}, 32'(out_code), exp);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_code"}, 32'(out_code), exp);
    check({tag, "_in_ready_passthru"}, 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int k;
    int saw_valid;
    logic [8:0] rmask;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 4'd0;
    in_err_mask = 9'd0;
    out_ready   = 1'b0;

    // Reset held two cycles.
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);

    // N=13 clean: code 247.
    run_txn(13, 9'h000, 0, "n13");

    // Full clean sweep.
    for (int n = 0; n < 16; n++) begin
      run_txn(n, 9'h000, 0, $sformatf("sweep%0d", n));
    end

    // Single-bit injected error: 247 ^ 4 = 243.
    run_txn(13, 9'h004, 0, "mask4");

    // Backpressure for 10 cycles on N=7.
    run_txn(7, 9'h000, 10, "bp7");

    // Back-to-back: N=3 then N=5 with in_valid held high.
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_data     = 4'd3;
    in_err_mask = 9'd0;
    tick();
    in_data = 4'd5;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    t1 = cyc;
    check("b2b_first_code", 32'(out_code), 32'd57);
    check("b2b_accept_in_done", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    t2 = cyc;
    check("b2b_second_code", 32'(out_code), 32'd95);
    check("b2b_spacing", 32'(t2 - t1), 32'd5);
    tick();
    out_ready = 1'b0;
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of MUL aborts the transaction.
    in_valid = 1'b1;
    in_data  = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) saw_valid = 1;
      tick();
    end
    check("midrst_no_valid", 32'(saw_valid), 32'd0);
    check("midrst_idle_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_code", 32'(out_code), 32'd0);

    // Randomized traffic with random masks, hold times and idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 0) rmask = 9'd0;
      else rmask = 9'($urandom);
      run_txn(int'($urandom_range(15, 0)), rmask, int'($urandom_range(3, 0)),
              $sformatf("rand%0d", i));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/an_encoder_seq.md
Name: an_encoder_seq

Overview:
- Sequential AN-code encoder for the decoder stage downstream (A=19, 4-bit data, 9-bit code word).
- Takes a data word N and produces the code word A*N using a shift-and-add multiplier that processes one data bit per cycle.
- Valid/ready handshakes on both sides.
- An optional error mask, latched with the data and XORed onto the result, lets the downstream decoder's single-bit correction be exercised in-system.

Parameters:
- A, 19, AN-code modulus (odd, constant).
- N_W, 4, data width.
- A_W, 5, bit width of A.
- AN_W, 9, code word width. Must satisfy (2^N_W-1)*A < 2^AN_W; a static elaboration check enforces this.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream presents data.
- in_ready  output  1  block can accept data.
- in_data  input  N_W  data word N.
- in_err_mask  input  AN_W  error-injection mask, XORed onto the code word; 0 = clean.
- out_valid  output  1  code word available.
- out_ready  input  1  downstream accepts the code word.
- out_code  output  AN_W  (A*N) XOR mask.

Behaviour:
- Reset: rst_n low at a rising edge gives:
  - state=IDLE;
  - acc, n_reg, mask_reg and cnt all 0;
  - out_valid=0, out_code=0, in_ready=1 on the cycle after the edge.
  - Reset mid-MUL or mid-DONE aborts the transaction; the partial result is discarded and never presented.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
    - latch n_reg=in_data, mask_reg=in_err_mask;
    - set acc=0, cnt=0;
    - go to MUL.
  - MUL: in_ready=0, out_valid=0. Each cycle:
    - acc <= acc + (n_reg[cnt] ? (A << cnt) : 0), computed in AN_W bits; no overflow is possible by the parameter constraint;
    - cnt increments.
    - When cnt==N_W-1, the final add is performed and the state goes to DONE.
  - DONE: out_valid=1, out_code=acc ^ mask_reg, held stable while out_ready=0.
    - On out_ready=1, the word is consumed.
    - in_ready = out_ready in this state, a combinational pass-through that allows back-to-back operation.
    - If in_valid is also high, the new word is latched and the state goes directly to MUL. Otherwise the state goes to IDLE.
- Latency:
  - Accept at edge E0; MUL occupies E1..E_N_W; out_valid is high in the cycle following edge E_N_W, i.e. N_W cycles after the accept edge.
  - Throughput is one word per N_W+1 cycles back-to-back, and one per N_W+2 cycles via IDLE.
- Handshake rules:
  - out_code and out_valid never change while out_valid=1 and out_ready=0.
  - in_valid is ignored when in_ready=0, and in_data is not sampled then.
  - out_ready in IDLE or MUL has no effect.
- Mask: applied only at the output; acc always holds the clean A*N.
  - A mask with one bit set models a single-bit error of ±2^i.
  - Multi-bit masks are legal and simply passed through.
- out_code is registered-state derived (acc, mask_reg) with no combinational path from inputs. The only combinational input-to-output path is out_ready -> in_ready in DONE.

Decomposition:
- Shared package an_code_pkg holds:
  - constants A, N_W, A_W, AN_W (shared with the decoder so the modulus and widths cannot diverge);
  - the state enum {IDLE, MUL, DONE};
  - a function computing the required AN_W, used by the static check.
- No sub-module: the FSM and the single shift-add datapath stay in one module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release. Required: in_ready=1, out_valid=0, out_code=0.
- N=13, mask=0, out_ready=1. Required: out_valid rises exactly 4 cycles after the accept edge with out_code=247; 247 % 19 == 0.
- Sweep N=0..15 with mask=0. Required: out_code=19*N for every N (N=0 gives 0, N=15 gives 285); no overflow.
- N=13, mask=9'h004. Required: out_code=243. Fed to the decoder, this must return 13.
- Backpressure: N=7 with out_ready=0 for 10 cycles. Required: out_code=133 and out_valid=1 held stable throughout, in_ready=0; consumed on the first out_ready=1 cycle.
- Back-to-back and reset:
  - in_valid held high with N=3 then N=5, out_ready=1. Required: second accept happens in the DONE cycle; codes 57 then 95, 5 cycles apart.
  - Separately, assert rst_n=0 during MUL. Required: no out_valid appears and the block returns to IDLE.
